// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, engine state encoding and defaults.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned ADDR_W_DEFAULT  = 32;
  localparam int unsigned DATA_W_DEFAULT  = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RSP     = 3'd5
  } state_e;

  // States in which a bus access is outstanding and the watchdog runs
  function automatic logic is_busy(input state_e s);
    return (s == ST_WR_AW_W) || (s == ST_WR_B) || (s == ST_RD_AR) || (s == ST_RD_R);
  endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// Bus watchdog: cleared on load, counts enabled cycles, flags the last allowed cycle.
module axi_lite_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired_c
);

  localparam bit          ENABLED = (TIMEOUT_CYCLES > 0);
  localparam int unsigned CNT_W   = ENABLED ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned LAST    = ENABLED ? TIMEOUT_CYCLES - 1 : 0;

  logic [CNT_W-1:0] cnt_q;

  assign expired_c = ENABLED && enable && (cnt_q == CNT_W'(LAST));

  // A zero timeout ties the counter off permanently
  always_ff @(posedge clk) begin
    if (rst || !ENABLED) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (enable && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axi_lite_master_engine.sv
// AXI4-Lite initiator: one command in flight, fully registered channel outputs,
// watchdog abort of hung accesses.
module axi_lite_master_engine
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] axi_lite_awaddr,
  output logic              axi_lite_awvalid,
  input  logic              axi_lite_awready,
  output logic [DATA_W-1:0] axi_lite_wdata,
  output logic              axi_lite_wvalid,
  input  logic              axi_lite_wready,
  input  logic [1:0]        axi_lite_bresp,
  input  logic              axi_lite_bvalid,
  output logic              axi_lite_bready,
  output logic [ADDR_W-1:0] axi_lite_araddr,
  output logic              axi_lite_arvalid,
  input  logic              axi_lite_arready,
  input  logic [DATA_W-1:0] axi_lite_rdata,
  input  logic [1:0]        axi_lite_rresp,
  input  logic              axi_lite_rvalid,
  output logic              axi_lite_rready
);

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d, rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                wd_load_c, wd_expired_c;

  axi_lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (axi_aclk),
    .rst       (axi_areset),
    .load      (wd_load_c),
    .enable    (is_busy(state_q)),
    .expired_c (wd_expired_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    wd_load_c     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wd_load_c     = 1'b1;
          rsp_write_d   = cmd_write;
          rsp_timeout_d = 1'b0;
          if (cmd_write) begin
            state_d   = ST_WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
          end else begin
            state_d   = ST_RD_AR;
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
          end
        end
      end
      ST_WR_AW_W: begin
        // AW and W complete independently, in either order
        if (axi_lite_awready) awvalid_d = 1'b0;
        if (axi_lite_wready)  wvalid_d  = 1'b0;
        if ((!awvalid_q || axi_lite_awready) && (!wvalid_q || axi_lite_wready)) begin
          state_d  = ST_WR_B;
          bready_d = 1'b1;
        end
      end
      ST_WR_B: begin
        if (axi_lite_bvalid) begin
          state_d     = ST_RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = axi_lite_bresp;
          rsp_rdata_d = '0;
        end
      end
      ST_RD_AR: begin
        if (axi_lite_arready) begin
          state_d   = ST_RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      ST_RD_R: begin
        if (axi_lite_rvalid) begin
          state_d     = ST_RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_resp_d  = axi_lite_rresp;
          rsp_rdata_d = axi_lite_rdata;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A beat landing on the expiry cycle still completes normally
    if (wd_expired_c && (state_d != ST_RSP)) begin
      state_d       = ST_RSP;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = RESP_SLVERR;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
    end

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_write        = rsp_write_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_resp         = rsp_resp_q;
  assign rsp_timeout      = rsp_timeout_q;
  assign axi_lite_awaddr  = awaddr_q;
  assign axi_lite_awvalid = awvalid_q;
  assign axi_lite_wdata   = wdata_q;
  assign axi_lite_wvalid  = wvalid_q;
  assign axi_lite_bready  = bready_q;
  assign axi_lite_araddr  = araddr_q;
  assign axi_lite_arvalid = arvalid_q;
  assign axi_lite_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_engine.sv
// Directed bench for axi_lite_master_engine against a small configurable AXI-Lite slave.
module tb_axi_lite_master_engine;

  logic        axi_aclk = 1'b0;
  logic        axi_areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [31:0] axi_lite_awaddr;
  logic        axi_lite_awvalid;
  logic        axi_lite_awready = 1'b0;
  logic [31:0] axi_lite_wdata;
  logic        axi_lite_wvalid;
  logic        axi_lite_wready = 1'b0;
  logic [1:0]  axi_lite_bresp = 2'b00;
  logic        axi_lite_bvalid = 1'b0;
  logic        axi_lite_bready;
  logic [31:0] axi_lite_araddr;
  logic        axi_lite_arvalid;
  logic        axi_lite_arready = 1'b0;
  logic [31:0] axi_lite_rdata = '0;
  logic [1:0]  axi_lite_rresp = 2'b00;
  logic        axi_lite_rvalid = 1'b0;
  logic        axi_lite_rready;

  int n_cmp = 0;
  int n_err = 0;

  // Slave configuration (written only by the main sequence)
  int aw_wait = 0;
  int w_wait  = 0;
  int ar_wait = 0;

  // Slave state (written only by the slave process)
  logic [31:0] mem [16] = '{default: 32'h0};
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  int aw_seen = 0, w_seen = 0, ar_seen = 0;
  bit bready_seen = 1'b0;
  bit got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic p_awvalid = 1'b0, p_wvalid = 1'b0, p_arvalid = 1'b0, p_bready = 1'b0, p_rready = 1'b0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

  axi_lite_master_engine #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .axi_lite_awaddr(axi_lite_awaddr), .axi_lite_awvalid(axi_lite_awvalid),
    .axi_lite_awready(axi_lite_awready),
    .axi_lite_wdata(axi_lite_wdata), .axi_lite_wvalid(axi_lite_wvalid),
    .axi_lite_wready(axi_lite_wready),
    .axi_lite_bresp(axi_lite_bresp), .axi_lite_bvalid(axi_lite_bvalid),
    .axi_lite_bready(axi_lite_bready),
    .axi_lite_araddr(axi_lite_araddr), .axi_lite_arvalid(axi_lite_arvalid),
    .axi_lite_arready(axi_lite_arready),
    .axi_lite_rdata(axi_lite_rdata), .axi_lite_rresp(axi_lite_rresp),
    .axi_lite_rvalid(axi_lite_rvalid), .axi_lite_rready(axi_lite_rready)
  );

  always #5 axi_aclk = ~axi_aclk;

  // Slave: on each falling edge, retire handshakes of the rising edge just passed, then drive
  always @(negedge axi_aclk) begin
    if (p_awvalid && axi_lite_awready) begin got_aw = 1'b1; s_awaddr = p_awaddr; aw_hs_n++; end
    if (p_wvalid && axi_lite_wready)   begin got_w  = 1'b1; s_wdata  = p_wdata;  w_hs_n++;  end
    if (p_bready && axi_lite_bvalid)   begin axi_lite_bvalid = 1'b0; b_hs_n++; end
    if (p_arvalid && axi_lite_arready) begin got_ar = 1'b1; s_araddr = p_araddr; ar_hs_n++; end
    if (p_rready && axi_lite_rvalid)   begin axi_lite_rvalid = 1'b0; r_hs_n++; end
    if (got_aw && got_w) begin
      mem[s_awaddr[5:2]] = s_wdata;
      axi_lite_bresp = 2'b00; axi_lite_bvalid = 1'b1;
      got_aw = 1'b0; got_w = 1'b0;
    end
    if (got_ar) begin
      axi_lite_rdata = mem[s_araddr[5:2]];
      axi_lite_rresp = 2'b00; axi_lite_rvalid = 1'b1;
      got_ar = 1'b0;
    end
    axi_lite_awready = axi_lite_awvalid && (aw_seen >= aw_wait);
    axi_lite_wready  = axi_lite_wvalid  && (w_seen  >= w_wait);
    axi_lite_arready = axi_lite_arvalid && (ar_seen >= ar_wait);
    if (axi_lite_awvalid) aw_seen++; else aw_seen = 0;
    if (axi_lite_wvalid)  w_seen++;  else w_seen  = 0;
    if (axi_lite_arvalid) ar_seen++; else ar_seen = 0;
    if (axi_lite_bready) bready_seen = 1'b1;
    p_awvalid = axi_lite_awvalid; p_awaddr = axi_lite_awaddr;
    p_wvalid  = axi_lite_wvalid;  p_wdata  = axi_lite_wdata;
    p_arvalid = axi_lite_arvalid; p_araddr = axi_lite_araddr;
    p_bready  = axi_lite_bready;  p_rready = axi_lite_rready;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge axi_aclk);
  endtask

  // Present a command and return on the falling edge of the cycle after acceptance
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int k;
    k = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && k < 50) begin step(); k++; end
    check("cmd_ready_before_accept", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Cycles counted from the cycle after acceptance (that cycle = 1)
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 64) begin step(); cyc++; end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_valid_after_consume", rsp_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int lat, hold, bad, aw0, w0, b0, ar0, r0;

    // Reset state
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", axi_lite_awvalid, 0);
    check("rst_wvalid", axi_lite_wvalid, 0);
    check("rst_arvalid", axi_lite_arvalid, 0);
    check("rst_bready", axi_lite_bready, 0);
    check("rst_rready", axi_lite_rready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_awaddr", axi_lite_awaddr, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    axi_areset = 1'b0;
    step();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // 1: zero-wait write
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    issue(1'b1, 32'h0000_0000, 32'h02E9_0EDD);
    check("t1_awvalid", axi_lite_awvalid, 1);
    check("t1_wvalid", axi_lite_wvalid, 1);
    check("t1_awaddr", axi_lite_awaddr, 32'h0000_0000);
    check("t1_wdata", axi_lite_wdata, 32'h02E9_0EDD);
    check("t1_cmd_ready_busy", cmd_ready, 0);
    wait_rsp(lat);
    check("t1_latency", lat, 3);
    check("t1_rsp_write", rsp_write, 1);
    check("t1_rsp_resp", rsp_resp, 2'b00);
    check("t1_rsp_timeout", rsp_timeout, 0);
    check("t1_rsp_rdata", rsp_rdata, 0);
    consume();
    #1;
    check("t1_aw_hs", aw_hs_n - aw0, 1);
    check("t1_w_hs", w_hs_n - w0, 1);
    check("t1_b_hs", b_hs_n - b0, 1);
    check("t1_bready_seen", bready_seen, 1);

    // 2: zero-wait read-back
    ar0 = ar_hs_n; r0 = r_hs_n;
    step();
    issue(1'b0, 32'h0000_0000, 32'h0);
    check("t2_arvalid", axi_lite_arvalid, 1);
    check("t2_araddr", axi_lite_araddr, 32'h0000_0000);
    wait_rsp(lat);
    check("t2_latency", lat, 3);
    check("t2_rsp_rdata", rsp_rdata, 32'h02E9_0EDD);
    check("t2_rsp_resp", rsp_resp, 2'b00);
    check("t2_rsp_write", rsp_write, 0);
    consume();
    #1;
    check("t2_ar_hs", ar_hs_n - ar0, 1);
    check("t2_r_hs", r_hs_n - r0, 1);

    // 3: W accepted five cycles before AW
    aw_wait = 5; w_wait = 0;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    step();
    issue(1'b1, 32'h0000_0008, 32'hA5A5_0003);
    step();
    check("t3_wvalid_dropped", axi_lite_wvalid, 0);
    check("t3_awvalid_held", axi_lite_awvalid, 1);
    hold = 0; bad = 0;
    while (axi_lite_awvalid && hold < 40) begin
      if (axi_lite_awaddr !== 32'h0000_0008 || axi_lite_wvalid !== 1'b0) bad++;
      hold++;
      step();
    end
    check("t3_aw_extra_cycles", hold, 5);
    check("t3_aw_stable", bad, 0);
    wait_rsp(lat);
    check("t3_rsp_resp", rsp_resp, 2'b00);
    check("t3_rsp_write", rsp_write, 1);
    consume();
    #1;
    check("t3_aw_hs", aw_hs_n - aw0, 1);
    check("t3_w_hs", w_hs_n - w0, 1);
    check("t3_b_hs", b_hs_n - b0, 1);
    aw_wait = 0;

    // 5: response back-pressure with a new command waiting
    step();
    issue(1'b0, 32'h0000_0008, 32'h0);
    wait_rsp(lat);
    check("t5_latency", lat, 3);
    cmd_write = 1'b1; cmd_addr = 32'h0000_000C; cmd_wdata = 32'h1234_5678; cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0003 || rsp_resp !== 2'b00 ||
          cmd_ready !== 1'b0 || axi_lite_awvalid !== 1'b0 || axi_lite_wvalid !== 1'b0 ||
          axi_lite_arvalid !== 1'b0 || axi_lite_rready !== 1'b0) bad++;
      step();
    end
    check("t5_hold_stable", bad, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t5_rsp_valid_consumed", rsp_valid, 0);
    check("t5_cmd_ready_after", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    check("t5_next_awvalid", axi_lite_awvalid, 1);
    check("t5_next_awaddr", axi_lite_awaddr, 32'h0000_000C);
    wait_rsp(lat);
    check("t5_next_latency", lat, 3);
    consume();

    // 4: slave never answers, watchdog of 16 cycles
    aw_wait = 1000; w_wait = 1000;
    step();
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    hold = 0;
    while (axi_lite_awvalid && hold < 40) begin hold++; step(); end
    check("t4_busy_cycles", hold, 16);
    check("t4_wvalid", axi_lite_wvalid, 0);
    check("t4_bready", axi_lite_bready, 0);
    check("t4_rsp_valid", rsp_valid, 1);
    check("t4_rsp_timeout", rsp_timeout, 1);
    check("t4_rsp_resp", rsp_resp, 2'b10);
    check("t4_rsp_rdata", rsp_rdata, 0);
    consume();
    aw_wait = 0; w_wait = 0;
    step();
    issue(1'b0, 32'h0000_000C, 32'h0);
    wait_rsp(lat);
    check("t4_after_latency", lat, 3);
    check("t4_after_rdata", rsp_rdata, 32'h1234_5678);
    check("t4_after_timeout", rsp_timeout, 0);
    check("t4_after_resp", rsp_resp, 2'b00);
    consume();

    // 6: reset while a read address is pending
    ar_wait = 1000;
    step();
    issue(1'b0, 32'h0000_0004, 32'h0);
    check("t6_arvalid_pending", axi_lite_arvalid, 1);
    step();
    axi_areset = 1'b1;
    step();
    axi_areset = 1'b0;
    check("t6_arvalid_reset", axi_lite_arvalid, 0);
    check("t6_rsp_valid_reset", rsp_valid, 0);
    check("t6_rready_reset", axi_lite_rready, 0);
    step();
    check("t6_cmd_ready", cmd_ready, 1);
    ar_wait = 0;
    issue(1'b0, 32'h0000_0000, 32'h0);
    wait_rsp(lat);
    check("t6_after_latency", lat, 3);
    check("t6_after_rdata", rsp_rdata, 32'h02E9_0EDD);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
